// File: rtl/rock_ramp_sequencer_pkg.sv
// Shared types for the cradle-motor setpoint ramp: levels, FSM states, step directions.
package rock_pkg;

  localparam int unsigned LEVEL_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    WAIT = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    F_DN = 3'd0,
    A_DN = 3'd1,
    A_UP = 3'd2,
    F_UP = 3'd3,
    NONE = 3'd4
  } step_dir_e;

  typedef struct packed {
    logic [LEVEL_W-1:0] a;
    logic [LEVEL_W-1:0] f;
  } level_pair_t;

  // Down-ramps shed frequency before amplitude; up-ramps raise amplitude first.
  function automatic step_dir_e pick_step(input level_pair_t cur, input level_pair_t tgt);
    step_dir_e dir;
    if (cur.f > tgt.f)      dir = F_DN;
    else if (cur.a > tgt.a) dir = A_DN;
    else if (cur.a < tgt.a) dir = A_UP;
    else if (cur.f < tgt.f) dir = F_UP;
    else                    dir = NONE;
    return dir;
  endfunction

  function automatic level_pair_t apply_step(input level_pair_t cur, input step_dir_e dir);
    level_pair_t nx;
    nx = cur;
    case (dir)
      F_DN:    nx.f = cur.f - LEVEL_W'(1);
      A_DN:    nx.a = cur.a - LEVEL_W'(1);
      A_UP:    nx.a = cur.a + LEVEL_W'(1);
      F_UP:    nx.f = cur.f + LEVEL_W'(1);
      default: nx = cur;
    endcase
    return nx;
  endfunction

endpackage

// File: rtl/rock_ramp_sequencer_dwell_timer.sv
// Loadable saturating down-counter; used for the step dwell and the idle watchdog.
module dwell_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset)                        r_cnt <= '0;
    else if (i_load)                  r_cnt <= i_load_val;
    else if (i_dec && (r_cnt != '0))  r_cnt <= r_cnt - W'(1);
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/rock_ramp_sequencer.sv
// Ramps the (A, F) motor setpoints one level per DWELL cycles toward an accepted target.
// Optional idle watchdog that ramps back to 0/0: define RAMP_TIMEOUT_EN.
module rock_ramp_sequencer
  import rock_pkg::*;
#(
  parameter int unsigned DWELL = 1024
`ifdef RAMP_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 65536
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tgt_valid,
  output logic               tgt_ready,
  input  logic [LEVEL_W-1:0] tgt_A,
  input  logic [LEVEL_W-1:0] tgt_F,
  input  logic               stop,
  output logic [LEVEL_W-1:0] A,
  output logic [LEVEL_W-1:0] F,
  output logic               busy,
  output logic               settled,
  output logic               timeout
);

  localparam int unsigned DW_W = $clog2(DWELL);

  state_e      r_state, w_state_nx;
  level_pair_t r_lvl, w_lvl_nx;
  level_pair_t r_tgt, w_tgt_nx, w_tgt_eff;
  step_dir_e   w_dir;
  logic        r_busy, r_settled, w_settled_nx;
  logic        w_xfer, w_dw_load, w_dw_done, w_fire;

  assign tgt_ready = !reset && !stop && ((r_state == IDLE) || (r_state == WAIT));
  assign w_xfer    = tgt_valid && tgt_ready;
  // stop overrides the latched target immediately, even for a STEP already under way
  assign w_tgt_eff = stop ? level_pair_t'('0) : r_tgt;
  assign w_dir     = pick_step(r_lvl, w_tgt_eff);

  dwell_timer #(.W(DW_W)) u_dwell (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_dw_load),
    .i_load_val (DW_W'(DWELL - 2)),
    .i_dec      (r_state == WAIT),
    .o_done     (w_dw_done)
  );

`ifdef RAMP_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT);

  logic w_wd_run, w_wd_done, r_timeout;

  assign w_wd_run = (r_state == IDLE) && (r_lvl != '0) && !w_xfer && !stop;
  assign w_fire   = w_wd_run && w_wd_done;

  dwell_timer #(.W(WD_W)) u_watchdog (
    .clk        (clk),
    .reset      (reset),
    .i_load     (!w_wd_run),
    .i_load_val (WD_W'(TIMEOUT - 1)),
    .i_dec      (w_wd_run),
    .o_done     (w_wd_done)
  );

  always_ff @(posedge clk) begin
    if (reset) r_timeout <= 1'b0;
    else       r_timeout <= w_fire;
  end

  assign timeout = r_timeout;
`else
  assign w_fire  = 1'b0;
  assign timeout = 1'b0;
`endif

  // Next-state, next-level and target-latch logic
  always_comb begin
    w_state_nx   = r_state;
    w_lvl_nx     = r_lvl;
    w_tgt_nx     = r_tgt;
    w_settled_nx = 1'b0;
    w_dw_load    = 1'b0;

    if (stop)        w_tgt_nx = '0;
    else if (w_xfer) w_tgt_nx = '{a: tgt_A, f: tgt_F};

    case (r_state)
      IDLE: begin
        if (w_xfer || (stop && (r_lvl != '0))) begin
          w_state_nx = STEP;
        end else if (w_fire) begin
          w_tgt_nx   = '0;
          w_state_nx = STEP;
        end
      end
      STEP: begin
        if (w_dir == NONE) begin
          w_settled_nx = 1'b1;
          w_state_nx   = IDLE;
        end else begin
          w_lvl_nx   = apply_step(r_lvl, w_dir);
          w_dw_load  = 1'b1;
          w_state_nx = WAIT;
        end
      end
      WAIT: begin
        if (w_dw_done) w_state_nx = STEP;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_lvl     <= '0;
      r_tgt     <= '0;
      r_busy    <= 1'b0;
      r_settled <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_lvl     <= w_lvl_nx;
      r_tgt     <= w_tgt_nx;
      r_busy    <= (w_state_nx != IDLE);
      r_settled <= w_settled_nx;
    end
  end

  assign A       = r_lvl.a;
  assign F       = r_lvl.f;
  assign busy    = r_busy;
  assign settled = r_settled;

endmodule

// File: tb/tb_rock_ramp_sequencer.sv
// Directed bench for rock_ramp_sequencer with DWELL=4 (TIMEOUT=16 when RAMP_TIMEOUT_EN is defined).
module tb_rock_ramp_sequencer;

  logic       clk;
  logic       reset;
  logic       tgt_valid;
  logic       tgt_ready;
  logic [2:0] tgt_A;
  logic [2:0] tgt_F;
  logic       stop;
  logic [2:0] A;
  logic [2:0] F;
  logic       busy;
  logic       settled;
  logic       timeout;

  int n_cmp = 0;
  int n_err = 0;

  // Expected {A,F} after each step, octal digits A then F (6'o32 = A3 F2)
  logic [5:0] exp_seq [8];

  rock_ramp_sequencer #(
    .DWELL   (4)
`ifdef RAMP_TIMEOUT_EN
    ,
    .TIMEOUT (16)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tgt_valid (tgt_valid),
    .tgt_ready (tgt_ready),
    .tgt_A     (tgt_A),
    .tgt_F     (tgt_F),
    .stop      (stop),
    .A         (A),
    .F         (F),
    .busy      (busy),
    .settled   (settled),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL sim_time_limit: got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [2:0] a, input logic [2:0] f);
    tgt_valid = 1'b1;
    tgt_A     = a;
    tgt_F     = f;
  endtask

  // Walk cycles k_first..k_last after an accepting edge; step i is held for cycles 4i+1..4i+4
  task automatic follow(input string tag, input int n, input int k_first, input int k_last);
    for (int k = k_first; k <= k_last; k++) begin
      tick();
      if (k <= 4 * n) begin
        chk($sformatf("%s_af%0d", tag, k), 32'({A, F}), 32'(exp_seq[(k - 1) / 4]));
        chk($sformatf("%s_busy%0d", tag, k), 32'(busy), 32'd1);
        chk($sformatf("%s_settled%0d", tag, k), 32'(settled), 32'd0);
      end else begin
        chk($sformatf("%s_af%0d", tag, k), 32'({A, F}), 32'(exp_seq[n - 1]));
        chk($sformatf("%s_busy%0d", tag, k), 32'(busy), 32'd0);
        chk($sformatf("%s_settled%0d", tag, k), 32'(settled), 32'd1);
      end
    end
    if (k_last == 4 * n + 1) begin
      tick();
      chk($sformatf("%s_settled_end", tag), 32'(settled), 32'd0);
    end
  endtask

  initial begin
    reset     = 1'b1;
    tgt_valid = 1'b0;
    tgt_A     = 3'd0;
    tgt_F     = 3'd0;
    stop      = 1'b0;
    tick();
    tick();
    chk("rst_af", 32'({A, F}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_settled", 32'(settled), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_ready", 32'(tgt_ready), 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_ready", 32'(tgt_ready), 32'd1);

    // Ramp up 0/0 -> 3/2
    offer(3'd3, 3'd2);
    tick();
    tgt_valid = 1'b0;
    exp_seq = '{6'o10, 6'o20, 6'o30, 6'o31, 6'o32, 6'o00, 6'o00, 6'o00};
    follow("up", 5, 1, 21);

    // Ramp down 3/2 -> 1/0
    offer(3'd1, 3'd0);
    tick();
    tgt_valid = 1'b0;
    exp_seq = '{6'o31, 6'o30, 6'o20, 6'o10, 6'o00, 6'o00, 6'o00, 6'o00};
    follow("dn", 4, 1, 17);

    // Retarget while waiting: head for 3/2, switch to 1/0 after A reaches 2
    offer(3'd3, 3'd2);
    tick();
    tgt_valid = 1'b0;
    tick();
    chk("rt_af1", 32'({A, F}), 32'o20);
    chk("rt_ready_wait", 32'(tgt_ready), 32'd1);
    offer(3'd1, 3'd0);
    tick();
    tgt_valid = 1'b0;
    chk("rt_af2", 32'({A, F}), 32'o20);
    exp_seq = '{6'o20, 6'o10, 6'o00, 6'o00, 6'o00, 6'o00, 6'o00, 6'o00};
    follow("rt", 2, 3, 9);

    // stop at 2/1 during a ramp to 2/2, with a competing offer held high
    offer(3'd2, 3'd2);
    tick();
    tgt_valid = 1'b0;
    exp_seq = '{6'o20, 6'o21, 6'o20, 6'o10, 6'o00, 6'o00, 6'o00, 6'o00};
    follow("sp", 5, 1, 5);
    stop = 1'b1;
    offer(3'd3, 3'd3);
    #1;
    chk("sp_ready", 32'(tgt_ready), 32'd0);
    follow("sp", 5, 6, 21);
    tick();
    chk("sp_hold_af", 32'({A, F}), 32'o00);
    chk("sp_hold_busy", 32'(busy), 32'd0);
    stop      = 1'b0;
    tgt_valid = 1'b0;
    #1;
    chk("sp_release_ready", 32'(tgt_ready), 32'd1);

    // Ramp 0/0 -> 2/2, then offer the same pair again
    offer(3'd2, 3'd2);
    tick();
    tgt_valid = 1'b0;
    exp_seq = '{6'o10, 6'o20, 6'o21, 6'o22, 6'o00, 6'o00, 6'o00, 6'o00};
    follow("up2", 4, 1, 17);
    offer(3'd2, 3'd2);
    tick();
    tgt_valid = 1'b0;
    chk("eq_busy0", 32'(busy), 32'd1);
    chk("eq_af0", 32'({A, F}), 32'o22);
    chk("eq_settled0", 32'(settled), 32'd0);
    tick();
    chk("eq_busy1", 32'(busy), 32'd0);
    chk("eq_af1", 32'({A, F}), 32'o22);
    chk("eq_settled1", 32'(settled), 32'd1);
    tick();
    chk("eq_settled2", 32'(settled), 32'd0);

    // Reset in the middle of a ramp aborts it without a settled pulse
    offer(3'd3, 3'd3);
    tick();
    tgt_valid = 1'b0;
    tick();
    chk("mr_af1", 32'({A, F}), 32'o32);
    reset = 1'b1;
    tick();
    chk("mr_af", 32'({A, F}), 32'o00);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_ready", 32'(tgt_ready), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("mr_settled%0d", k), 32'(settled), 32'd0);
      chk($sformatf("mr_hold_af%0d", k), 32'({A, F}), 32'o00);
    end

`ifdef RAMP_TIMEOUT_EN
    // Settle at 1/1 and idle until the watchdog ramps back to 0/0
    offer(3'd1, 3'd1);
    tick();
    tgt_valid = 1'b0;
    exp_seq = '{6'o10, 6'o11, 6'o00, 6'o00, 6'o00, 6'o00, 6'o00, 6'o00};
    follow("to", 2, 1, 9);
    for (int j = 2; j <= 15; j++) begin
      tick();
      chk($sformatf("to_quiet%0d", j), 32'(timeout), 32'd0);
    end
    tick();
    chk("to_fire", 32'(timeout), 32'd1);
    chk("to_fire_busy", 32'(busy), 32'd1);
    chk("to_fire_af", 32'({A, F}), 32'o11);
    exp_seq = '{6'o10, 6'o00, 6'o00, 6'o00, 6'o00, 6'o00, 6'o00, 6'o00};
    follow("to_dn", 2, 1, 9);
    chk("to_after", 32'(timeout), 32'd0);
`else
    chk("no_wd_timeout", 32'(timeout), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
